wordle_score_engine: RTL and testbench
======================================

WORDLE_SCORE_ENGINE -- requirements
Module: wordle_score_engine

Interface
REQ-001 SHALL have parameter WORD_LEN, default 5, letters per word (range 2..8).
REQ-002 SHALL have parameter MAX_GUESSES, default 6, guess rows per game (range 1..8).
REQ-003 SHALL have parameter LETTER_W, default 8, bits per letter code (ASCII).
REQ-004 SHALL have port Clk input 1: the single clock.
REQ-005 SHALL have port reset input 1: synchronous, active-high reset.
REQ-006 SHALL have port new_game input 1: one-cycle pulse that latches secret and starts a game.
REQ-007 SHALL have port secret input WORD_LEN*LETTER_W: target word; position 0 is in the MSBs.
REQ-008 SHALL have port guess input WORD_LEN*LETTER_W: guessed word; position 0 is in the MSBs.
REQ-009 SHALL have port guess_valid input 1: guess offered.
REQ-010 SHALL have port guess_ready output 1: engine accepts a guess this cycle.
REQ-011 SHALL have port result_valid output 1: one-cycle pulse when a row is scored.
REQ-012 SHALL have port colors output 2*WORD_LEN: per-letter code (00 absent, 01 yellow, 10 green); position 0 is in the MSBs.
REQ-013 SHALL have port row output 3: index of the row just scored.
REQ-014 SHALL have port rd_row input 3 and port rd_colors output 2*WORD_LEN: combinational read of stored row colors, for VGA.
REQ-015 SHALL have ports win output 1 and lose output 1: sticky game-over flags.
REQ-016 SHALL have port reject output 1: one-cycle pulse when a guess is refused (hard mode only).

Function
REQ-017 SHALL use states IDLE, READY, CHECK (hard mode only), GREEN, YELLOW, POST, OVER.
REQ-018 In IDLE, guess_ready SHALL be 0; new_game latches secret, clears history and the row counter, clears win/lose, and moves to READY.
REQ-019 In READY, guess_ready SHALL be 1; guess_valid=1 latches guess and moves to GREEN (CHECK if hard mode).
REQ-020 Guess_ready SHALL be 0 in all states other than READY.
REQ-021 GREEN SHALL take one cycle per position i = 0..WORD_LEN-1: guess[i]==secret[i] marks i green and marks secret slot i consumed.
REQ-022 YELLOW SHALL take one cycle per non-green position i in ascending order: the lowest unconsumed secret slot j with secret[j]==guess[i] marks i yellow and consumes j; otherwise i is absent.
REQ-023 YELLOW SHALL also spend one cycle on each green position, doing nothing, so scoring latency is fixed.
REQ-024 Under REQ-021 and REQ-022, duplicate letters SHALL never be credited more times than they occur in secret.
REQ-025 POST SHALL write colors into history[row] and pulse result_valid with colors and row valid.
REQ-026 Without hard mode, result_valid SHALL assert exactly 2*WORD_LEN+1 cycles after the accept cycle.
REQ-027 If all positions are green, POST SHALL set win and move to OVER.
REQ-028 Otherwise, if row==MAX_GUESSES-1, POST SHALL set lose and move to OVER.
REQ-029 Otherwise, POST SHALL increment row and return to READY.
REQ-030 In OVER, the engine SHALL hold win/lose; only new_game leaves OVER.
REQ-031 new_game SHALL be honoured in every state and restart the game.
REQ-032 If new_game and guess_valid assert in the same cycle, new_game SHALL win and the guess is ignored.
REQ-033 Rows not yet written SHALL read 00 on every letter.
REQ-034 rd_row >= MAX_GUESSES SHALL read all zeros.

Reset
REQ-035 reset SHALL force IDLE.
REQ-036 reset SHALL clear guess_ready, result_valid, reject, win, lose, colors, row, all history rows and the latched secret/guess.
REQ-037 reset SHALL take precedence over new_game.
REQ-038 reset asserted mid-scoring SHALL abort the row with no result_valid and no history write.

Configuration
REQ-039 When macro WORDLE_HARD_MODE_EN is defined, an accepted guess SHALL first spend WORD_LEN cycles in CHECK.
REQ-040 In CHECK, every position that was green in any earlier row of the game SHALL be required to hold the same letter.
REQ-041 On a CHECK violation, the engine SHALL pulse reject, not consume a row, not write history, and return to READY.
REQ-042 On a CHECK pass, the engine SHALL proceed to GREEN, and result latency SHALL be 3*WORD_LEN+1 cycles.
REQ-043 Without WORDLE_HARD_MODE_EN, the CHECK state and its logic SHALL be absent and reject SHALL be tied to 0.

Verification
REQ-044 Defaults, secret "CRANE", guess "CRANE" -> result_valid at accept+11, colors 10_10_10_10_10, row 0, win=1, guess_ready=0.
REQ-045 Secret "CRANE", guess "EERIE" -> colors 00_00_01_00_10 (only the final E green; R yellow; the other Es absent).
REQ-046 Secret "CRANE", six guesses "PILOT" -> rows 0..5 all 00, lose=1 after the sixth result_valid, and a seventh guess_valid is never accepted.
REQ-047 reset pulsed at accept+4 -> no result_valid, rd_row 0 reads 0, guess_ready=0 until new_game.
REQ-048 guess_valid held high during scoring -> exactly one accept per READY visit; new_game together with guess_valid -> guess ignored, row counter 0.
REQ-049 With WORDLE_HARD_MODE_EN, secret "CRANE", row0 "CLOUD" (C green), then guess "SLATE" -> reject pulse, row stays 1; then guess "CHASE" -> accepted, result_valid at accept+16.

Source files
------------

// File: rtl/wordle_score_engine.sv
`default_nettype none
// ============================================================================
// Module      : wordle_score_engine
// Description : Sequential Wordle row scorer with per-game colour history.
//               Optional hard mode enabled by macro WORDLE_HARD_MODE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wordle_score_engine #(
    parameter int WORD_LEN    = 5,
    parameter int MAX_GUESSES = 6,
    parameter int LETTER_W    = 8
) (
    input  logic                         Clk,
    input  logic                         reset,
    input  logic                         new_game,
    input  logic [WORD_LEN*LETTER_W-1:0] secret,
    input  logic [WORD_LEN*LETTER_W-1:0] guess,
    input  logic                         guess_valid,
    output logic                         guess_ready,
    output logic                         result_valid,
    output logic [2*WORD_LEN-1:0]        colors,
    output logic [2:0]                   row,
    input  logic [2:0]                   rd_row,
    output logic [2*WORD_LEN-1:0]        rd_colors,
    output logic                         win,
    output logic                         lose,
    output logic                         reject
);

    localparam int c_IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READY  = 3'd1,
        S_GREEN  = 3'd2,
        S_YELLOW = 3'd3,
        S_POST   = 3'd4,
`ifdef WORDLE_HARD_MODE_EN
        S_CHECK  = 3'd6,
`endif
        S_OVER   = 3'd5
    } state_t;

    state_t r_state, w_next;

    logic [WORD_LEN*LETTER_W-1:0] r_secret, r_guess;
    logic [c_IDX_W-1:0]           r_idx;
    logic [WORD_LEN-1:0]          r_consumed;
    logic [1:0]                   r_col [WORD_LEN];
    logic [2*WORD_LEN-1:0]        r_hist [8];
    logic [2:0]                   r_row;
    logic                         r_win, r_lose;

    logic [LETTER_W-1:0]          w_sec_l [WORD_LEN];
    logic [LETTER_W-1:0]          w_gss_l [WORD_LEN];
    logic [WORD_LEN-1:0]          w_green;
    logic                         w_last_idx, w_match, w_all_green, w_y_found;
    logic [c_IDX_W-1:0]           w_y_j;

    // Position 0 lives in the MSBs of every packed word and colour vector.
    for (genvar p = 0; p < WORD_LEN; p++) begin : g_unpack
        assign w_sec_l[p] = r_secret[(WORD_LEN-1-p)*LETTER_W +: LETTER_W];
        assign w_gss_l[p] = r_guess[(WORD_LEN-1-p)*LETTER_W +: LETTER_W];
        assign colors[(WORD_LEN-1-p)*2 +: 2] = r_col[p];
        assign w_green[p] = (r_col[p] == 2'b10);
    end

    assign w_last_idx   = (r_idx == c_IDX_W'(WORD_LEN-1));
    assign w_match      = (w_sec_l[r_idx] == w_gss_l[r_idx]);
    assign w_all_green  = &w_green;
    assign guess_ready  = (r_state == S_READY);
    assign result_valid = (r_state == S_POST);
    assign row          = r_row;
    assign win          = r_win;
    assign lose         = r_lose;
    assign rd_colors    = ({1'b0, rd_row} < 4'(MAX_GUESSES)) ? r_hist[rd_row] : '0;

    // Descending scan so the lowest matching unconsumed slot wins.
    always_comb begin
        w_y_found = 1'b0;
        w_y_j     = '0;
        for (int j = WORD_LEN-1; j >= 0; j--) begin
            if (!r_consumed[j] && (w_sec_l[j] == w_gss_l[r_idx])) begin
                w_y_found = 1'b1;
                w_y_j     = c_IDX_W'(j);
            end
        end
    end

`ifdef WORDLE_HARD_MODE_EN
    logic [WORD_LEN-1:0] r_gmask;
    logic                r_viol;
    logic                w_chk_bad;
    assign w_chk_bad = r_gmask[r_idx] && !w_match;
    assign reject    = (r_state == S_CHECK) && w_last_idx && (r_viol || w_chk_bad);
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_READY: begin
                if (guess_valid) begin
`ifdef WORDLE_HARD_MODE_EN
                    w_next = S_CHECK;
`else
                    w_next = S_GREEN;
`endif
                end
            end
`ifdef WORDLE_HARD_MODE_EN
            S_CHECK:  if (w_last_idx) w_next = reject ? S_READY : S_GREEN;
`endif
            S_GREEN:  if (w_last_idx) w_next = S_YELLOW;
            S_YELLOW: if (w_last_idx) w_next = S_POST;
            S_POST:   w_next = (w_all_green || (r_row == 3'(MAX_GUESSES-1))) ? S_OVER : S_READY;
            default:  w_next = r_state;
        endcase
        if (new_game) w_next = S_READY;
    end

    always_ff @(posedge Clk) begin
        if (reset || new_game) begin
            r_secret   <= reset ? '0 : secret;
            r_guess    <= '0;
            r_idx      <= '0;
            r_consumed <= '0;
            r_row      <= '0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            for (int k = 0; k < WORD_LEN; k++) r_col[k] <= 2'b00;
            for (int k = 0; k < 8; k++) r_hist[k] <= '0;
`ifdef WORDLE_HARD_MODE_EN
            r_gmask    <= '0;
            r_viol     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_READY: begin
                    if (guess_valid) begin
                        r_guess    <= guess;
                        r_idx      <= '0;
                        r_consumed <= '0;
                        for (int k = 0; k < WORD_LEN; k++) r_col[k] <= 2'b00;
`ifdef WORDLE_HARD_MODE_EN
                        r_viol     <= 1'b0;
`endif
                    end
                end
`ifdef WORDLE_HARD_MODE_EN
                S_CHECK: begin
                    if (w_chk_bad) r_viol <= 1'b1;
                    r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
                end
`endif
                S_GREEN: begin
                    if (w_match) begin
                        r_col[r_idx]      <= 2'b10;
                        r_consumed[r_idx] <= 1'b1;
                    end
                    r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
                end
                S_YELLOW: begin
                    if (!w_green[r_idx] && w_y_found) begin
                        r_col[r_idx]      <= 2'b01;
                        r_consumed[w_y_j] <= 1'b1;
                    end
                    r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
                end
                S_POST: begin
                    r_hist[r_row] <= colors;
`ifdef WORDLE_HARD_MODE_EN
                    r_gmask <= r_gmask | w_green;
`endif
                    if (w_all_green)                          r_win  <= 1'b1;
                    else if (r_row == 3'(MAX_GUESSES-1))      r_lose <= 1'b1;
                    else                                      r_row  <= r_row + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wordle_score_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_wordle_score_engine
// Description : Directed, table-driven checks for wordle_score_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wordle_score_engine;

    localparam int WL = 5;
`ifdef WORDLE_HARD_MODE_EN
    localparam int LAT = 3*WL+1;
`else
    localparam int LAT = 2*WL+1;
`endif

    logic          Clk = 1'b0;
    logic          reset, new_game, guess_valid;
    logic [WL*8-1:0] secret, guess;
    logic          guess_ready, result_valid, win, lose, reject;
    logic [2*WL-1:0] colors, rd_colors;
    logic [2:0]    row, rd_row;

    always #5 Clk = ~Clk;

    wordle_score_engine dut (
        .Clk(Clk), .reset(reset), .new_game(new_game), .secret(secret),
        .guess(guess), .guess_valid(guess_valid), .guess_ready(guess_ready),
        .result_valid(result_valid), .colors(colors), .row(row),
        .rd_row(rd_row), .rd_colors(rd_colors), .win(win), .lose(lose),
        .reject(reject)
    );

    int checks = 0;
    int errors = 0;

    logic [2*WL-1:0] cap_colors;
    logic [2:0]      cap_row;
    int              cap_lat;
    logic            cap_rej;

    typedef struct {
        logic [39:0] s;
        logic [39:0] g;
        logic [9:0]  col;
        logic        w;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_new_game(input logic [39:0] s);
        @(negedge Clk);
        secret   = s;
        new_game = 1'b1;
        @(negedge Clk);
        new_game = 1'b0;
    endtask

    // Offers one guess; records cycles from accept to result/reject.
    task automatic play(input logic [39:0] g);
        int n;
        cap_lat = -1;
        cap_rej = 1'b0;
        n = 0;
        while (!guess_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (!guess_ready) begin
            errors++;
            $display("FAIL ready_timeout: guess_ready never rose");
            return;
        end
        guess       = g;
        guess_valid = 1'b1;
        @(posedge Clk);
        #1 guess_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (result_valid || reject) begin
                cap_lat    = i;
                cap_rej    = reject;
                cap_colors = colors;
                cap_row    = row;
                break;
            end
        end
    endtask

    initial begin
        int cnt;
        vecs[0] = '{"CRANE", "CRANE", 10'b1010101010, 1'b1};
        vecs[1] = '{"CRANE", "EERIE", 10'b0000010010, 1'b0};
        vecs[2] = '{"CRANE", "PILOT", 10'b0000000000, 1'b0};
        vecs[3] = '{"CRANE", "NACRE", 10'b0101010110, 1'b0};
        vecs[4] = '{"ABBEY", "BBBBB", 10'b0010100000, 1'b0};
        vecs[5] = '{"LEVEL", "EELLL", 10'b0110010010, 1'b0};

        reset = 1'b1; new_game = 1'b0; guess_valid = 1'b0;
        secret = '0; guess = '0; rd_row = 3'd0;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        chk("rst_ready",  guess_ready,  0);
        chk("rst_rvalid", result_valid, 0);
        chk("rst_win",    win,          0);
        chk("rst_lose",   lose,         0);
        chk("rst_colors", colors,       0);
        chk("rst_row",    row,          0);
        chk("rst_reject", reject,       0);

        for (int v = 0; v < 6; v++) begin
            do_new_game(vecs[v].s);
            play(vecs[v].g);
            chk("vec_latency", cap_lat,    LAT);
            chk("vec_colors",  cap_colors, vecs[v].col);
            chk("vec_row",     cap_row,    0);
            @(negedge Clk);
            rd_row = 3'd0;
            #1;
            chk("vec_win",     win,        vecs[v].w);
            chk("vec_hist",    rd_colors,  vecs[v].col);
            chk("vec_ready",   guess_ready, !vecs[v].w);
        end

        rd_row = 3'd1; #1 chk("unwritten_row", rd_colors, 0);
        rd_row = 3'd7; #1 chk("row_oob",       rd_colors, 0);
        do_new_game("CRANE");
        rd_row = 3'd0; #1 chk("hist_cleared",  rd_colors, 0);

        // Six misses then a locked-out seventh attempt.
        for (int k = 0; k < 6; k++) begin
            play("PILOT");
            chk("lose_latency", cap_lat,    LAT);
            chk("lose_row",     cap_row,    k);
            chk("lose_colors",  cap_colors, 0);
        end
        @(negedge Clk);
        chk("lose_flag",   lose,        1);
        chk("lose_nowin",  win,         0);
        chk("lose_ready",  guess_ready, 0);
        guess_valid = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge Clk);
            if (result_valid || guess_ready) cnt++;
        end
        guess_valid = 1'b0;
        chk("lose_locked", cnt, 0);

        // guess_valid held high: one accept per READY visit.
        do_new_game("CRANE");
        guess = "PILOT";
        guess_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2*(LAT+1); i++) begin
            if (guess_ready) cnt++;
            @(negedge Clk);
        end
        guess_valid = 1'b0;
        chk("hold_accepts", cnt, 2);
        chk("hold_row",     row, 2);
        chk("hold_ready",   guess_ready, 1);

        // new_game and guess_valid together: guess dropped.
        @(negedge Clk);
        secret = "CRANE"; guess = "CRANE";
        new_game = 1'b1; guess_valid = 1'b1;
        @(posedge Clk);
        #1 new_game = 1'b0; guess_valid = 1'b0;
        @(negedge Clk);
        chk("collide_ready", guess_ready, 1);
        chk("collide_row",   row,         0);
        cnt = 0;
        repeat (LAT+4) begin
            @(negedge Clk);
            if (result_valid) cnt++;
        end
        chk("collide_noresult", cnt, 0);

        // Reset in the middle of scoring aborts the row.
        do_new_game("CRANE");
        guess = "CRANE";
        guess_valid = 1'b1;
        @(posedge Clk);
        #1 guess_valid = 1'b0;
        repeat (4) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge Clk);
            if (result_valid || guess_ready || win) cnt++;
        end
        chk("abort_quiet", cnt, 0);
        rd_row = 3'd0; #1 chk("abort_hist", rd_colors, 0);
        do_new_game("CRANE");
        chk("abort_restart", guess_ready, 1);

`ifdef WORDLE_HARD_MODE_EN
        do_new_game("CRANE");
        play("CLOUD");
        chk("hard_row0_colors", cap_colors, 10'b1000000000);
        play("SLATE");
        chk("hard_reject",     cap_rej, 1);
        chk("hard_reject_lat", cap_lat, WL);
        @(negedge Clk);
        chk("hard_row_kept",   row,     1);
        play("CHASE");
        chk("hard_pass_rej",    cap_rej,    0);
        chk("hard_pass_lat",    cap_lat,    3*WL+1);
        chk("hard_pass_row",    cap_row,    1);
        chk("hard_pass_colors", cap_colors, 10'b1000100010);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
